// File: rtl/avalon_bus_arbiter.sv
// Two-port Avalon-MM arbiter: m0 (ifetch) and m1 (load/store) share one
// downstream master port with a registered round-robin grant.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   m{0,1}_address      requester byte address (32)
//   m{0,1}_read/write   requester strobes (write wins if both are set)
//   m{0,1}_writedata    requester write data (32)
//   m{0,1}_byteenable   requester byte lanes (4)
//   m{0,1}_waitrequest  stall back to each requester
//   m{0,1}_readdata     downstream readdata, passed through
//   address/read/write/writedata/byteenable  downstream request
//   waitrequest/readdata                     downstream response
//   grant               one-hot owner (01 = m0, 10 = m1, 00 = idle)
module avalon_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   req0;
  logic   req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign grant = {state == GNT1, state == GNT0};

  assign m0_readdata = readdata;
  assign m1_readdata = readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      unique case (state)
        GNT0: begin
          if (req0 && !waitrequest) begin
            last  <= 1'b0;
            state <= req1 ? GNT1 : IDLE;
          end else if (!req0) begin
            state <= IDLE;
          end
        end
        GNT1: begin
          if (req1 && !waitrequest) begin
            last  <= 1'b1;
            state <= req0 ? GNT0 : IDLE;
          end else if (!req1) begin
            state <= IDLE;
          end
        end
        default: begin
          // On a tie the port that was not served last wins.
          if (req0 && req1)
            state <= last ? GNT0 : GNT1;
          else if (req0)
            state <= GNT0;
          else if (req1)
            state <= GNT1;
          else
            state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    address        = '0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = '0;
    byteenable     = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    unique case (1'b1)
      state == GNT0: begin
        address        = m0_address;
        read           = m0_read & ~m0_write;
        write          = m0_write;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        m0_waitrequest = waitrequest;
      end
      state == GNT1: begin
        address        = m1_address;
        read           = m1_read & ~m1_write;
        write          = m1_write;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        m1_waitrequest = waitrequest;
      end
      default: begin
      end
    endcase
  end

endmodule
